// File: rtl/jk_blink_ctrl.sv
// Blink sequencer for a j/k set/clear cell: SET/ON/CLR/OFF periods with q feedback and timeout.
// Optional abort path enabled by defining JK_BLINK_ABORT_EN.
module jk_blink_ctrl #(
    parameter int CW = 8,
    parameter int NW = 4,
    parameter int TO = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] on_len,
    input  logic [CW-1:0] off_len,
    input  logic [NW-1:0] n_cycles,
    input  logic          q_fb,
`ifdef JK_BLINK_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic          j,
    output logic          k,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int AW = (TO > 2) ? $clog2(TO) : 2;
    localparam logic [AW-1:0] ACK_LAST = AW'(TO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET,
        S_ON,
        S_CLR,
        S_OFF,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] ack_cnt, ack_nxt;
    logic [CW-1:0] phase_cnt, phase_nxt;
    logic [NW-1:0] rem_cnt, rem_nxt;
    logic [CW-1:0] on_reg, on_nxt;
    logic [CW-1:0] off_reg, off_nxt;
    logic          abort_flag, flag_nxt;
    logic          aborted_nxt;
    logic          aborted_reg;
    logic          abort_req;
    logic [CW-1:0] on_last;
    logic [CW-1:0] off_last;

`ifdef JK_BLINK_ABORT_EN
    assign abort_req = abort;
    assign aborted   = aborted_reg;
`else
    assign abort_req = 1'b0;
`endif

    // A zero phase length behaves as one cycle.
    assign on_last  = (on_reg == '0)  ? '0 : on_reg - CW'(1);
    assign off_last = (off_reg == '0) ? '0 : off_reg - CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ack_cnt     <= '0;
            phase_cnt   <= '0;
            rem_cnt     <= '0;
            on_reg      <= '0;
            off_reg     <= '0;
            abort_flag  <= 1'b0;
            j           <= 1'b0;
            k           <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            aborted_reg <= 1'b0;
        end else begin
            state       <= state_nxt;
            ack_cnt     <= ack_nxt;
            phase_cnt   <= phase_nxt;
            rem_cnt     <= rem_nxt;
            on_reg      <= on_nxt;
            off_reg     <= off_nxt;
            abort_flag  <= flag_nxt;
            j           <= (state_nxt == S_SET);
            k           <= (state_nxt == S_CLR);
            busy        <= (state_nxt == S_SET) || (state_nxt == S_ON) ||
                           (state_nxt == S_CLR) || (state_nxt == S_OFF);
            done        <= (state_nxt == S_DONE);
            err         <= (state_nxt == S_ERR);
            aborted_reg <= aborted_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ack_nxt     = ack_cnt;
        phase_nxt   = phase_cnt;
        rem_nxt     = rem_cnt;
        on_nxt      = on_reg;
        off_nxt     = off_reg;
        flag_nxt    = abort_flag;
        aborted_nxt = 1'b0;

        case (state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    on_nxt    = on_len;
                    off_nxt   = off_len;
                    rem_nxt   = n_cycles;
                    ack_nxt   = '0;
                    phase_nxt = '0;
                    flag_nxt  = 1'b0;
                    state_nxt = (n_cycles == '0) ? S_DONE : S_SET;
                end
            end

            S_SET: begin
                if (abort_req) begin
                    flag_nxt  = 1'b1;
                    ack_nxt   = '0;
                    state_nxt = S_CLR;
                end else if (q_fb) begin
                    ack_nxt   = '0;
                    phase_nxt = '0;
                    state_nxt = S_ON;
                end else if (ack_cnt == ACK_LAST) begin
                    ack_nxt   = '0;
                    state_nxt = S_ERR;
                end else begin
                    ack_nxt = ack_cnt + AW'(1);
                end
            end

            S_ON: begin
                if (abort_req) begin
                    flag_nxt  = 1'b1;
                    ack_nxt   = '0;
                    phase_nxt = '0;
                    state_nxt = S_CLR;
                end else if (phase_cnt == on_last) begin
                    ack_nxt   = '0;
                    phase_nxt = '0;
                    state_nxt = S_CLR;
                end else begin
                    phase_nxt = phase_cnt + CW'(1);
                end
            end

            // An abort arriving here only arms the flag; the exit waits for the next edge.
            S_CLR: begin
                flag_nxt = abort_flag | abort_req;
                if (!q_fb && !abort_req) begin
                    ack_nxt = '0;
                    if (abort_flag) begin
                        flag_nxt    = 1'b0;
                        aborted_nxt = 1'b1;
                        state_nxt   = S_IDLE;
                    end else begin
                        phase_nxt = '0;
                        state_nxt = S_OFF;
                    end
                end else if (ack_cnt == ACK_LAST) begin
                    ack_nxt   = '0;
                    flag_nxt  = 1'b0;
                    state_nxt = S_ERR;
                end else begin
                    ack_nxt = ack_cnt + AW'(1);
                end
            end

            S_OFF: begin
                if (abort_req) begin
                    flag_nxt  = 1'b1;
                    ack_nxt   = '0;
                    phase_nxt = '0;
                    state_nxt = S_CLR;
                end else if (phase_cnt == off_last) begin
                    phase_nxt = '0;
                    rem_nxt   = rem_cnt - NW'(1);
                    state_nxt = (rem_cnt == NW'(1)) ? S_DONE : S_SET;
                end else begin
                    phase_nxt = phase_cnt + CW'(1);
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifndef JK_BLINK_ABORT_EN
    logic unused_ok;
    assign unused_ok = aborted_reg;
`endif

endmodule
